perceptron_layer: RTL and testbench
===================================

PERCEPTRON_LAYER -- requirements
Module: perceptron_layer

Interface
REQ-001 SHALL have parameter N, default 4: inputs per neuron, N >= 1.
REQ-002 SHALL have parameter M, default 2: neurons in the layer, M >= 1.
REQ-003 SHALL have parameter DATA_WIDTH, default 8: width of every signed two's-complement data/weight/bias/output element.
REQ-004 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-006 SHALL have port in_valid  input  1  x/w/b/mode are valid this cycle.
REQ-007 SHALL have port in_ready  output  1  block can accept an input set.
REQ-008 SHALL have port x  input  N x DATA_WIDTH signed  shared input vector.
REQ-009 SHALL have port w  input  M x N x DATA_WIDTH signed  weight matrix, w[m][n].
REQ-010 SHALL have port b  input  M x DATA_WIDTH signed  per-neuron bias.
REQ-011 SHALL have port mode  input  2  activation: 0 identity, 1 ReLU, 2 step, 3 identity (reserved).
REQ-012 SHALL have port out_valid  output  1  y holds a completed result.
REQ-013 SHALL have port out_ready  input  1  consumer accepts y this cycle.
REQ-014 SHALL have port y  output  M x DATA_WIDTH signed  per-neuron activated outputs.
REQ-015 SHALL have port busy  output  1  high while in COMPUTE.

Function
REQ-016 SHALL implement FSM states IDLE, COMPUTE, DONE; in_ready = (state==IDLE), out_valid = (state==DONE), busy = (state==COMPUTE).
REQ-017 SHALL, on an edge with in_valid && in_ready, register x, w, b, mode and enter COMPUTE with neuron index m=0, input index n=0; later input changes SHALL not affect the result.
REQ-018 SHALL use one shared signed multiplier; each COMPUTE edge adds x[n]*w[m][n] to the accumulator, starting from b[m] sign-extended at n=0.
REQ-019 SHALL size the accumulator at 2*DATA_WIDTH + clog2(N+1) + 1 bits so no intermediate overflow occurs.
REQ-020 SHALL, on the edge consuming n=N-1, write activated, saturated result into y[m], reset n to 0 and advance m; after m=M-1 enter DONE.
REQ-021 SHALL assert out_valid exactly N*M rising edges after the accepting edge.
REQ-022 SHALL apply identity: y = clamp(acc) to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
REQ-023 SHALL apply ReLU: y = 0 if acc < 0 else clamp(acc).
REQ-024 SHALL apply step: y = 1 if acc > 0 else 0 (acc = 0 gives 0).
REQ-025 SHALL hold y and out_valid stable in DONE until an edge with out_ready high, then return to IDLE; y SHALL keep its value in IDLE.
REQ-026 SHALL ignore in_valid while in COMPUTE or DONE (no queuing, no overwrite of captured data).
REQ-027 SHALL ignore out_ready outside DONE.
REQ-028 SHALL leave y[m] for neurons not yet written unchanged during COMPUTE (previous result or reset value).

Reset
REQ-029 SHALL, while rst_n is low, force state IDLE, m=n=0, accumulator 0, all y elements 0, out_valid 0, busy 0, in_ready 1, independent of clk.
REQ-030 SHALL abort any COMPUTE or DONE on reset with no partial result retained.
REQ-031 SHALL accept a new input on the first rising edge after rst_n deasserts if in_valid is high.

Verification (N=3, M=2, DATA_WIDTH=8)
REQ-032 SHALL cover identity: x={1,2,3}, w0={1,1,1}, b0=4, w1={-1,0,0}, b1=0, mode=0 -> y={10,-1}, out_valid exactly 6 edges after accept.
REQ-033 SHALL cover ReLU and step: same vectors, mode=1 -> y={10,0}; mode=2 -> y={1,0}; w0={0,0,0}, b0=0, mode=2 -> y0=0.
REQ-034 SHALL cover saturation: x={127,127,127}, w0={127,127,127}, b0=127, w1={-128,-128,-128}, b1=-128, mode=0 -> y={127,-128}.
REQ-035 SHALL cover backpressure: out_ready low 10 cycles in DONE with in_valid high and x changing -> y constant, in_ready 0, out_valid 1; out_ready pulse -> IDLE next edge, in_ready 1.
REQ-036 SHALL cover reset mid-operation: rst_n low 3 edges after accept -> out_valid 0, busy 0, y={0,0}, in_ready 1 immediately; subsequent REQ-032 stimulus yields y={10,-1}.

Source files
------------

// File: rtl/perceptron_layer.sv
// Perceptron layer: M neurons over a shared N-element input vector.
// One signed multiplier is time-shared across all N*M products; each neuron's
// sum is activated (identity / ReLU / step) and saturated to DATA_WIDTH bits.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// S_IDLE    | waiting for in_valid; in_ready high, last y held
// S_COMPUTE | one multiply-accumulate per edge, neuron m, input n
// S_DONE    | y complete, out_valid high until out_ready
module perceptron_layer #(
   parameter int N          = 4,
   parameter int M          = 2,
   parameter int DATA_WIDTH = 8
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           in_valid,
   output logic                           in_ready,
   input  logic [N*DATA_WIDTH-1:0]        x,
   input  logic [M*N*DATA_WIDTH-1:0]      w,
   input  logic [M*DATA_WIDTH-1:0]        b,
   input  logic [1:0]                     mode,
   output logic                           out_valid,
   input  logic                           out_ready,
   output logic [M*DATA_WIDTH-1:0]        y,
   output logic                           busy
);

   localparam int DW = DATA_WIDTH;
   localparam int AW = 2*DW + $clog2(N+1) + 1;
   localparam int NW = (N > 1) ? $clog2(N) : 1;
   localparam int MW = (M > 1) ? $clog2(M) : 1;

   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_COMPUTE = 2'd1;
   localparam logic [1:0] S_DONE    = 2'd2;

   localparam logic [NW-1:0] N_LAST = NW'(N-1);
   localparam logic [MW-1:0] M_LAST = MW'(M-1);

   logic [1:0]               state;
   logic [N*DW-1:0]          x_r;
   logic [M*N*DW-1:0]        w_r;
   logic [M*DW-1:0]          b_r;
   logic [1:0]               mode_r;
   logic [NW-1:0]            n_idx;
   logic [MW-1:0]            m_idx;
   logic signed [AW-1:0]     acc;
   logic [M*DW-1:0]          y_r;

   logic signed [DW-1:0]     x_sel;
   logic signed [DW-1:0]     w_sel;
   logic signed [DW-1:0]     b_sel;
   logic signed [2*DW-1:0]   prod;
   logic signed [AW-1:0]     sum;
   logic [DW-1:0]            sat;
   logic [DW-1:0]            act;

   // Operand selection from the captured input set for the current (m, n)
   always_comb begin
      x_sel = '0;
      w_sel = '0;
      b_sel = '0;
      for (int i = 0; i < N; i++) begin
         if (n_idx == NW'(i)) x_sel = x_r[i*DW +: DW];
      end
      for (int j = 0; j < M; j++) begin
         if (m_idx == MW'(j)) begin
            b_sel = b_r[j*DW +: DW];
            for (int i = 0; i < N; i++) begin
               if (n_idx == NW'(i)) w_sel = w_r[(j*N+i)*DW +: DW];
            end
         end
      end
   end

   // Shared multiplier and accumulate; the bias seeds the sum at n=0
   always_comb begin
      prod = x_sel * w_sel;
      sum  = ((n_idx == '0) ? {{(AW-DW){b_sel[DW-1]}}, b_sel} : acc)
           + {{(AW-2*DW){prod[2*DW-1]}}, prod};
   end

   // Saturation to DW bits, then activation selected by the captured mode
   always_comb begin
      if (sum[AW-1:DW-1] == {(AW-DW+1){sum[AW-1]}})
         sat = sum[DW-1:0];
      else if (sum[AW-1])
         sat = {1'b1, {(DW-1){1'b0}}};
      else
         sat = {1'b0, {(DW-1){1'b1}}};
      case (mode_r)
         2'd1:    act = sum[AW-1] ? '0 : sat;
         2'd2:    act = (!sum[AW-1] && (|sum)) ? DW'(1) : '0;
         default: act = sat;
      endcase
   end

   // Sequencer: capture, per-product accumulate, per-neuron writeback, handoff
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= S_IDLE;
         x_r    <= '0;
         w_r    <= '0;
         b_r    <= '0;
         mode_r <= '0;
         n_idx  <= '0;
         m_idx  <= '0;
         acc    <= '0;
         y_r    <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (in_valid) begin
                  x_r    <= x;
                  w_r    <= w;
                  b_r    <= b;
                  mode_r <= mode;
                  n_idx  <= '0;
                  m_idx  <= '0;
                  acc    <= '0;
                  state  <= S_COMPUTE;
               end
            end
            S_COMPUTE: begin
               if (n_idx == N_LAST) begin
                  for (int j = 0; j < M; j++) begin
                     if (m_idx == MW'(j)) y_r[j*DW +: DW] <= act;
                  end
                  acc   <= '0;
                  n_idx <= '0;
                  if (m_idx == M_LAST) begin
                     m_idx <= '0;
                     state <= S_DONE;
                  end else begin
                     m_idx <= m_idx + MW'(1);
                  end
               end else begin
                  acc   <= sum;
                  n_idx <= n_idx + NW'(1);
               end
            end
            S_DONE: begin
               if (out_ready) state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign in_ready  = (state == S_IDLE);
   assign out_valid = (state == S_DONE);
   assign busy      = (state == S_COMPUTE);
   assign y         = y_r;

endmodule

// File: tb/tb_perceptron_layer.sv
// Scoreboard bench for perceptron_layer (N=3, M=2, DATA_WIDTH=8).
// Inputs change 1 time unit after the rising edge; outputs sampled on the falling edge.
module tb_perceptron_layer;
   localparam int N  = 3;
   localparam int M  = 2;
   localparam int DW = 8;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              in_valid = 1'b0;
   logic              in_ready;
   logic [N*DW-1:0]   x = '0;
   logic [M*N*DW-1:0] w = '0;
   logic [M*DW-1:0]   b = '0;
   logic [1:0]        mode = '0;
   logic              out_valid;
   logic              out_ready = 1'b0;
   logic [M*DW-1:0]   y;
   logic              busy;

   perceptron_layer #(.N(N), .M(M), .DATA_WIDTH(DW)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .x(x), .w(w), .b(b), .mode(mode), .out_valid(out_valid),
      .out_ready(out_ready), .y(y), .busy(busy)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_checks = 0;
   int n_pass   = 0;

   typedef struct {
      logic [M*DW-1:0] y;
      int              acc_cyc;
   } exp_t;
   exp_t exp_q[$];
   exp_t e_mon;

   bit rand_ready  = 1'b0;
   bit force_ready = 1'b0;
   bit seen        = 1'b0;

   int xs[N];
   int ws[M][N];
   int bs[M];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      n_checks++;
      if (act === expv) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
   endtask

   // Reference: full-precision sum, then activation and clamp on plain integers
   function automatic logic [M*DW-1:0] model(input int xv[N], input int wv[M][N],
                                             input int bv[M], input int md);
      logic [M*DW-1:0] r = '0;
      longint acc;
      int v;
      for (int m = 0; m < M; m++) begin
         acc = bv[m];
         for (int n = 0; n < N; n++) acc += longint'(xv[n]) * wv[m][n];
         if (md == 2)                 v = (acc > 0) ? 1 : 0;
         else if (md == 1 && acc < 0) v = 0;
         else if (acc > 127)          v = 127;
         else if (acc < -128)         v = -128;
         else                         v = int'(acc);
         r[m*DW +: DW] = 8'(v);
      end
      return r;
   endfunction

   function automatic int rs8();
      int sel = int'($urandom_range(0, 7));
      if (sel == 0) return -128;
      if (sel == 1) return 127;
      if (sel == 2) return 0;
      return int'($urandom_range(0, 255)) - 128;
   endfunction

   // Called at posedge+1; returns at posedge+1 of the accepting edge
   task automatic issue(input int xv[N], input int wv[M][N], input int bv[M],
                        input int md, input logic [M*DW-1:0] expy);
      int k = 0;
      while (!in_ready && k < 200) begin
         @(posedge clk); #1;
         k++;
      end
      if (!in_ready) begin
         chk("in_ready_timeout", in_ready, 1);
         return;
      end
      for (int n = 0; n < N; n++) x[n*DW +: DW] = 8'(xv[n]);
      for (int m = 0; m < M; m++) begin
         b[m*DW +: DW] = 8'(bv[m]);
         for (int n = 0; n < N; n++) w[(m*N+n)*DW +: DW] = 8'(wv[m][n]);
      end
      mode = 2'(md);
      in_valid = 1'b1;
      @(posedge clk); #1;
      exp_q.push_back('{y: expy, acc_cyc: cyc});
      chk("busy_after_accept", busy, 1);
      in_valid = 1'b0;
   endtask

   task automatic wait_drain();
      int k = 0;
      while (exp_q.size() != 0 && k < 500) begin
         @(posedge clk); #1;
         k++;
      end
      chk("drain_queue_empty", exp_q.size(), 0);
   endtask

   // Consumer handshake: random or forced
   always @(posedge clk) begin
      #1;
      out_ready = rand_ready ? 1'($urandom_range(0, 1)) : force_ready;
   end

   // Monitor: latency on first sight of out_valid, y on the handshake
   always @(negedge clk) begin
      if (!rst_n) begin
         seen = 1'b0;
      end else if (out_valid) begin
         if (exp_q.size() == 0) begin
            chk("spurious_out_valid", out_valid, 0);
         end else begin
            if (!seen) begin
               seen = 1'b1;
               chk("latency", cyc - exp_q[0].acc_cyc, N*M);
            end
            if (out_ready) begin
               e_mon = exp_q.pop_front();
               chk("y", y, e_mon.y);
               seen = 1'b0;
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1);
   end

   initial begin
      #3;
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_y", y, 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      force_ready = 1'b1;

      xs = '{1, 2, 3};
      ws = '{'{1, 1, 1}, '{-1, 0, 0}};
      bs = '{4, 0};
      issue(xs, ws, bs, 0, 16'hFF0A);
      issue(xs, ws, bs, 1, 16'h000A);
      issue(xs, ws, bs, 2, 16'h0001);
      issue(xs, ws, bs, 3, 16'hFF0A);
      ws = '{'{0, 0, 0}, '{-1, 0, 0}};
      bs = '{0, 0};
      issue(xs, ws, bs, 2, 16'h0000);
      xs = '{127, 127, 127};
      ws = '{'{127, 127, 127}, '{-128, -128, -128}};
      bs = '{127, -128};
      issue(xs, ws, bs, 0, 16'h807F);
      wait_drain();

      // Backpressure in DONE with new inputs presented
      force_ready = 1'b0;
      xs = '{1, 2, 3};
      ws = '{'{1, 1, 1}, '{-1, 0, 0}};
      bs = '{4, 0};
      issue(xs, ws, bs, 0, 16'hFF0A);
      for (int k = 0; k < 50 && !out_valid; k++) begin
         @(posedge clk); #1;
      end
      chk("bp_reach_done", out_valid, 1);
      for (int k = 0; k < 10; k++) begin
         @(posedge clk); #1;
         x = 24'($urandom);
         in_valid = 1'b1;
         @(negedge clk);
         chk("bp_y_hold", y, 16'hFF0A);
         chk("bp_in_ready", in_ready, 0);
         chk("bp_out_valid", out_valid, 1);
      end
      force_ready = 1'b1;
      in_valid = 1'b0;
      @(posedge clk);
      @(negedge clk);
      force_ready = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk("bp_idle_in_ready", in_ready, 1);
      chk("bp_idle_out_valid", out_valid, 0);
      chk("bp_idle_y_kept", y, 16'hFF0A);
      @(posedge clk); #1;

      // Reset three edges into a computation
      force_ready = 1'b1;
      issue(xs, ws, bs, 0, 16'hFF0A);
      repeat (3) @(posedge clk);
      #1;
      chk("pre_rst_busy", busy, 1);
      rst_n = 1'b0;
      exp_q.delete();
      #1;
      chk("midrst_out_valid", out_valid, 0);
      chk("midrst_busy", busy, 0);
      chk("midrst_y", y, 0);
      chk("midrst_in_ready", in_ready, 1);
      @(posedge clk);
      @(posedge clk); #1;
      rst_n = 1'b1;
      issue(xs, ws, bs, 0, 16'hFF0A);
      wait_drain();

      // Randomized traffic against the reference model
      rand_ready = 1'b1;
      for (int t = 0; t < 30; t++) begin
         int md;
         for (int n = 0; n < N; n++) xs[n] = rs8();
         for (int m = 0; m < M; m++) begin
            bs[m] = rs8();
            for (int n = 0; n < N; n++) ws[m][n] = rs8();
         end
         md = int'($urandom_range(0, 3));
         issue(xs, ws, bs, md, model(xs, ws, bs, md));
      end
      wait_drain();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
